// File: rtl/ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// ctrl_seq_if
//   Instruction fetch handshake between the control sequencer and the
//   instruction memory.
//
//   fetch_req  sequencer -> memory  request for the next instruction
//   fetch_ack  memory -> sequencer  instr carries a valid instruction this cycle
//   instr      memory -> sequencer  16-bit instruction word
//
//   master: the sequencer side, slave: the memory side.
// ---------------------------------------------------------------------------
interface ctrl_seq_if;
    logic        fetch_req;
    logic        fetch_ack;
    logic [15:0] instr;

    modport master (
        output fetch_req,
        input  fetch_ack,
        input  instr
    );

    modport slave (
        input  fetch_req,
        output fetch_ack,
        output instr
    );
endinterface

// File: rtl/ctrl_seq.sv
// ---------------------------------------------------------------------------
// ctrl_seq
//   Multicycle control sequencer for the register/ALU datapath. It fetches an
//   instruction over the fetch handshake, decodes it and walks
//   FETCH -> DECODE -> EXEC -> WB, driving the datapath control fields and the
//   packed control word. HALTED and FAULT are sticky until reset.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     run        1 = keep executing, 0 = stop after the current instruction
//     alu_cout   ALU carry-out, captured at the end of EXEC
//     fetch      fetch handshake (master side): fetch_req / fetch_ack / instr
//     input_a/b  source register selects
//     input_c    destination register select
//     cin, rec   ALU carry-in and operation (00 add, 01 sub, 10 and, 11 or)
//     pc_en      PC increment strobe (DECODE only)
//     reg_en     register-file write strobe (WB only)
//     ctrl_word  {0,input_a,0,input_b,cin,input_c,rec,pc_en,reg_en}
//     state      0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 WB, 5 HALTED, 6 FAULT
//     halted     1 while in HALTED
//     fault      1 while in FAULT
//
//   Every output is a flop. The output flops are loaded from the state being
//   entered, so each field is valid for exactly the cycle its state is in.
// ---------------------------------------------------------------------------
module ctrl_seq #(
    parameter int unsigned TIMEOUT = 15   // FETCH cycles without ack before FAULT (1..255)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        alu_cout,
    ctrl_seq_if.master  fetch,
    output logic [2:0]  input_a,
    output logic [2:0]  input_b,
    output logic [2:0]  input_c,
    output logic        cin,
    output logic [1:0]  rec,
    output logic        pc_en,
    output logic        reg_en,
    output logic [15:0] ctrl_word,
    output logic [2:0]  state,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5,
        S_FAULT  = 3'd6
    } state_e;

    typedef struct packed {
        logic       fetch_req;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
        logic       cin;
        logic [1:0] rec;
        logic       pc_en;
        logic       reg_en;
        logic       halted;
        logic       fault;
    } outs_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADC  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Timer value in the last FETCH cycle that may still accept an ack.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        carry_q, carry_d;
    logic [7:0]  timer_q, timer_d;
    outs_t       outs_q, outs_d;

    logic [3:0]  op;
    assign op = ir_q[15:12];

    // Instruction bits [2:0] are carried in IR but have no meaning.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[2:0];

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch can be inferred.
        state_d = state_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        timer_d = timer_q;
        outs_d  = '0;

        // ---------------- next state ----------------
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    timer_d = '0;
                end
            end
            S_FETCH: begin
                // An ack wins over the timeout, even in the last allowed cycle.
                if (fetch.fetch_ack) begin
                    ir_d    = fetch.instr;
                    state_d = S_DECODE;
                end else if (timer_q >= TIMER_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (op == OP_NOP)       state_d = S_WB;
                else if (op == OP_HALT) state_d = S_HALTED;
                else if (op <= OP_OR)   state_d = S_EXEC;
                else                    state_d = S_FAULT;
            end
            S_EXEC: begin
                state_d = S_WB;
                if (op inside {OP_ADD, OP_ADC, OP_SUB}) carry_d = alu_cout;
            end
            S_WB: begin
                if (run) begin
                    state_d = S_FETCH;
                    timer_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALTED, S_FAULT: begin
                state_d = state_q;
            end
            default: state_d = S_IDLE;
        endcase

        // ---------------- outputs for the state being entered ----------------
        case (state_d)
            S_FETCH:  outs_d.fetch_req = 1'b1;
            S_DECODE: outs_d.pc_en     = 1'b1;
            S_EXEC: begin
                outs_d.a = ir_q[8:6];
                outs_d.b = ir_q[5:3];
                outs_d.c = ir_q[11:9];
                case (op)
                    OP_ADC: outs_d.cin = carry_q;
                    OP_SUB: begin outs_d.rec = 2'b01; outs_d.cin = 1'b1; end
                    OP_AND: outs_d.rec = 2'b10;
                    OP_OR:  outs_d.rec = 2'b11;
                    default: outs_d.rec = 2'b00;   // ADD
                endcase
            end
            S_WB: begin
                // WB reuses the EXEC fields; a NOP arrives from DECODE and writes nothing.
                if (op != OP_NOP) begin
                    outs_d        = outs_q;
                    outs_d.reg_en = 1'b1;
                end
            end
            S_HALTED: outs_d.halted = 1'b1;
            S_FAULT:  outs_d.fault  = 1'b1;
            default:  outs_d        = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            carry_q <= 1'b0;
            timer_q <= '0;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            timer_q <= timer_d;
            outs_q  <= outs_d;
        end
    end

    assign fetch.fetch_req = outs_q.fetch_req;
    assign input_a   = outs_q.a;
    assign input_b   = outs_q.b;
    assign input_c   = outs_q.c;
    assign cin       = outs_q.cin;
    assign rec       = outs_q.rec;
    assign pc_en     = outs_q.pc_en;
    assign reg_en    = outs_q.reg_en;
    assign halted    = outs_q.halted;
    assign fault     = outs_q.fault;
    assign state     = state_q;
    assign ctrl_word = {1'b0, outs_q.a, 1'b0, outs_q.b, outs_q.cin, outs_q.c,
                        outs_q.rec, outs_q.pc_en, outs_q.reg_en};

endmodule

// File: tb/tb_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_ctrl_seq
//   Scoreboard bench for ctrl_seq. The driver acks instructions and pushes the
//   expected per-instruction response (computed from the opcode table and the
//   control-word packing) into a queue; a monitor pops an entry whenever the
//   DUT shows a pc_en pulse and compares the DECODE / EXEC / WB (or HALTED /
//   FAULT) cycles that follow. Directed sections cover reset, timeout,
//   run-drop and sticky states.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ctrl_seq;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        alu_cout = 1'b0;
    logic [2:0]  input_a, input_b, input_c;
    logic        cin;
    logic [1:0]  rec;
    logic        pc_en, reg_en;
    logic [15:0] ctrl_word;
    logic [2:0]  state;
    logic        halted, fault;

    ctrl_seq_if bus();

    ctrl_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .alu_cout  (alu_cout),
        .fetch     (bus),
        .input_a   (input_a),
        .input_b   (input_b),
        .input_c   (input_c),
        .cin       (cin),
        .rec       (rec),
        .pc_en     (pc_en),
        .reg_en    (reg_en),
        .ctrl_word (ctrl_word),
        .state     (state),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef enum int {K_ALU, K_NOP, K_HALT, K_FAULT} kind_e;
    typedef struct {
        kind_e       kind;
        logic [15:0] exec_word;
        logic [15:0] wb_word;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_carry  = 1'b0;   // reference carry flag
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: expected response of one instruction, from the opcode table.
    task automatic predict(input logic [15:0] ins, input logic cout, output exp_t e);
        logic [3:0] op;
        logic [1:0] rec_m;
        logic       cin_m;
        op = ins[15:12];
        e.exec_word = 16'h0000;
        e.wb_word   = 16'h0000;
        if (op == 4'd0)       e.kind = K_NOP;
        else if (op == 4'd15) e.kind = K_HALT;
        else if (op > 4'd5)   e.kind = K_FAULT;
        else begin
            e.kind = K_ALU;
            case (op)
                4'd3:    rec_m = 2'b01;
                4'd4:    rec_m = 2'b10;
                4'd5:    rec_m = 2'b11;
                default: rec_m = 2'b00;
            endcase
            cin_m = (op == 4'd3) ? 1'b1 : (op == 4'd2) ? m_carry : 1'b0;
            e.exec_word = {1'b0, ins[8:6], 1'b0, ins[5:3], cin_m, ins[11:9], rec_m, 2'b00};
            e.wb_word   = e.exec_word | 16'h0001;
            if (op <= 4'd3) m_carry = cout;
        end
    endtask

    // Wait (bounded) until the DUT requests a fetch; cyc = cycles waited.
    task automatic wait_fetch(output int cyc);
        cyc = 0;
        while (bus.fetch_req !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("wait_fetch_bound", 16'(bus.fetch_req), 16'd1);
    endtask

    // Called in a FETCH cycle: withhold ack for delay cycles, then ack ins.
    task automatic issue(input logic [15:0] ins, input int delay, input logic cout, input bit scored);
        exp_t e;
        repeat (delay) begin @(posedge clk); #1; end
        check("fetch_req_held", 16'(bus.fetch_req), 16'd1);
        predict(ins, cout, e);
        if (scored) exp_q.push_back(e);
        alu_cout      = cout;
        bus.fetch_ack = 1'b1;
        bus.instr     = ins;
        @(posedge clk); #1;
        bus.fetch_ack = 1'b0;
        bus.instr     = 16'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0;
        bus.fetch_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_carry = 1'b0;
        reset = 1'b1;
    endtask

    function automatic logic [15:0] rand_alu(input logic [3:0] op);
        logic [11:0] r;
        r = 12'($urandom);
        return {op, r};
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && reset && pc_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_decode", 16'(exp_q.size()), 16'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("decode_state", 16'(state), 16'd2);
                    check("decode_word", ctrl_word, 16'h0002);
                    @(negedge clk);
                    case (e.kind)
                        K_ALU: begin
                            check("exec_state", 16'(state), 16'd3);
                            check("exec_word", ctrl_word, e.exec_word);
                            check("exec_fields", {1'b0, input_a, 1'b0, input_b, cin, input_c,
                                                  rec, pc_en, reg_en}, e.exec_word);
                            check("exec_fetch_req", 16'(bus.fetch_req), 16'd0);
                            @(negedge clk);
                            check("wb_state", 16'(state), 16'd4);
                            check("wb_word", ctrl_word, e.wb_word);
                        end
                        K_NOP: begin
                            check("nop_wb_state", 16'(state), 16'd4);
                            check("nop_wb_word", ctrl_word, 16'h0000);
                        end
                        K_HALT: begin
                            check("halt_state", 16'(state), 16'd5);
                            check("halt_flag", 16'({halted, fault}), 16'b10);
                            check("halt_word", ctrl_word, 16'h0000);
                        end
                        default: begin
                            check("fault_state", 16'(state), 16'd6);
                            check("fault_flag", 16'({halted, fault}), 16'b01);
                            check("fault_word", ctrl_word, 16'h0000);
                        end
                    endcase
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        int cyc;
        logic [3:0] op;
        bus.fetch_ack = 1'b0;
        bus.instr     = 16'h0000;

        // Reset held from time 0.
        #3;
        check("rst_state", 16'(state), 16'd0);
        check("rst_word", ctrl_word, 16'h0000);
        check("rst_flags", 16'({bus.fetch_req, halted, fault}), 16'd0);
        do_reset();

        // fetch_ack outside FETCH is ignored.
        bus.fetch_ack = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("idle_ignores_ack", 16'({state, bus.fetch_req}), 16'd0);
        bus.fetch_ack = 1'b0;

        mon_en = 1'b1;
        run    = 1'b1;
        wait_fetch(cyc);
        check("idle_to_fetch", 16'(cyc), 16'd1);

        // ADD c5,a1,b2 acked in the first FETCH cycle.
        issue(16'h1A50, 0, 1'b0, 1'b1);
        wait_fetch(cyc);
        check("latency_add", 16'(cyc), 16'd3);

        // SUB with carry-out 1, then ADC picks up the carry.
        issue(rand_alu(4'd3), 0, 1'b1, 1'b1);
        wait_fetch(cyc);
        issue(rand_alu(4'd2), 0, 1'b0, 1'b1);
        wait_fetch(cyc);
        check("latency_adc", 16'(cyc), 16'd3);

        // Random instruction stream, ops 0..5, random ack delay and carry-out.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 5));
            issue(rand_alu(op), int'($urandom_range(0, 3)), 1'($urandom), 1'b1);
            wait_fetch(cyc);
            check("latency_rand", 16'(cyc), (op == 4'd0) ? 16'd2 : 16'd3);
        end

        // Ack on the last FETCH cycle before timeout is accepted.
        issue(rand_alu(4'd1), TIMEOUT - 1, 1'b0, 1'b1);
        wait_fetch(cyc);
        check("latency_late_ack", 16'(cyc), 16'd3);

        // run dropped during FETCH: request held, fetch completes, then IDLE.
        run = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("run0_fetch_held", 16'({state, bus.fetch_req}), 16'({3'd1, 1'b1}));
        issue(rand_alu(4'd5), 0, 1'b0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check("run0_fetch_idle", 16'({state, bus.fetch_req}), 16'd0);

        // run dropped during EXEC: one write-back, then IDLE with no fetch.
        run = 1'b1;
        wait_fetch(cyc);
        issue(rand_alu(4'd4), 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        check("run0_exec_wb", 16'(reg_en), 16'd1);
        repeat (4) begin @(posedge clk); #1; end
        check("run0_exec_idle", 16'({state, bus.fetch_req, reg_en}), 16'd0);

        // Async reset during EXEC of an AND; carry flag must clear.
        run = 1'b1;
        wait_fetch(cyc);
        issue(rand_alu(4'd3), 0, 1'b1, 1'b1);
        wait_fetch(cyc);
        mon_en = 1'b0;
        issue(rand_alu(4'd4), 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("and_exec_state", 16'(state), 16'd3);
        check("and_exec_rec", 16'(rec), 16'd2);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_state", 16'(state), 16'd0);
        check("async_rst_word", ctrl_word, 16'h0000);
        m_carry = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        wait_fetch(cyc);
        issue(rand_alu(4'd2), 0, 1'b0, 1'b1);   // ADC must see carry 0
        wait_fetch(cyc);

        // HALT: sticky, no write strobe, no fetch.
        issue(16'hF000, 0, 1'b0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        bus.fetch_ack = 1'b1;
        run = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk); #1;
        check("halt_sticky", 16'({state, halted, bus.fetch_req, reg_en}), 16'({3'd5, 1'b1, 2'b00}));
        do_reset();

        // Illegal opcode faults.
        run = 1'b1;
        wait_fetch(cyc);
        issue(rand_alu(4'($urandom_range(6, 14))), 0, 1'b0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check("illegal_sticky", 16'({state, fault, bus.fetch_req}), 16'({3'd6, 1'b1, 1'b0}));
        do_reset();

        // Fetch timeout: still fetching after TIMEOUT-1 silent cycles, FAULT after TIMEOUT.
        run = 1'b1;
        wait_fetch(cyc);
        repeat (TIMEOUT - 1) begin @(posedge clk); #1; end
        check("timeout_not_yet", 16'({state, bus.fetch_req}), 16'({3'd1, 1'b1}));
        @(posedge clk); #1;
        check("timeout_fault", 16'({state, fault, bus.fetch_req}), 16'({3'd6, 1'b1, 1'b0}));
        bus.fetch_ack = 1'b1;
        run = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        run = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("timeout_sticky", 16'({state, fault, bus.fetch_req}), 16'({3'd6, 1'b1, 1'b0}));
        do_reset();
        check("after_reset_idle", 16'({state, fault}), 16'd0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
